// File: rtl/mmcm_drp_reconfig_if.sv
// Request/completion handshake and DRP bus of the MMCM divider reconfiguration controller.
// The controller drives the DRP bus, so it takes the master modport.
interface mmcm_drp_reconfig_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_output;
  logic [7:0]  req_divide;
  logic        done_valid;
  logic [2:0]  done_status;
  logic        busy;
  logic        drp_en;
  logic        drp_we;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;

  modport master (
    input  req_valid, req_output, req_divide, drp_do, drp_rdy,
    output req_ready, done_valid, done_status, busy, drp_en, drp_we, drp_addr, drp_di
  );

  modport slave (
    output req_valid, req_output, req_divide, drp_do, drp_rdy,
    input  req_ready, done_valid, done_status, busy, drp_en, drp_we, drp_addr, drp_di
  );
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// Runtime reprogramming of one MMCME4 CLKOUTn integer divider over DRP.
// Holds the MMCM in reset, read-modify-writes ClkReg1/ClkReg2, releases reset and
// waits for LOCKED, gating the downstream BUFGCE CE across the update.
// Optional macro MMCM_DRP_READBACK_EN: verify each write with a readback (status 4 on mismatch).
module mmcm_drp_reconfig #(
  parameter int RST_HOLD     = 16,
  parameter int DRP_TIMEOUT  = 256,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  mmcm_drp_reconfig_if.master bus,
  output logic                mmcm_rst,
  input  logic                mmcm_locked,
  output logic                clk_en
);

  localparam int LOCK_BLANK = 4;
  localparam int CNT_MAX = (LOCK_TIMEOUT > DRP_TIMEOUT)
                         ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                         : ((DRP_TIMEOUT > RST_HOLD) ? DRP_TIMEOUT : RST_HOLD);
  localparam int CNT_W = $clog2(CNT_MAX + LOCK_BLANK + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RST_HOLD, S_RD1, S_WR1, S_VF1, S_RD2, S_WR2, S_VF2,
    S_RELEASE, S_LOCK_WAIT, S_DONE
  } state_t;

  // ClkReg1 address of each CLKOUT; ClkReg2 always sits at the next address.
  function automatic logic [6:0] reg1_addr(input logic [2:0] o);
    case (o)
      3'd0:    return 7'h08;
      3'd1:    return 7'h0A;
      3'd2:    return 7'h0C;
      3'd3:    return 7'h0E;
      3'd4:    return 7'h10;
      3'd5:    return 7'h06;
      default: return 7'h12;
    endcase
  endfunction

  // HIGH_TIME/LOW_TIME fields; 64 wraps to 0 in 6 bits, divide-by-1 uses 1/1.
  function automatic logic [11:0] enc_hilo(input logic [7:0] d);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = (d == 8'd1) ? 8'd1 : (d >> 1);
    lo = (d == 8'd1) ? 8'd1 : (d - hi);
    return {hi[5:0], lo[5:0]};
  endfunction

  // ClkReg2 keeps everything except EDGE (bit 7) and NO_COUNT (bit 6).
  function automatic logic [15:0] enc_reg2(input logic [15:0] old, input logic [7:0] d);
    return {old[15:8], d[0], (d == 8'd1), old[5:0]};
  endfunction

  // DRP failure dominates readback failure, which dominates the lock result.
  function automatic logic [2:0] final_status(input logic drp_err, input logic vf_err,
                                              input logic [2:0] lock_code);
    if (drp_err)     return 3'd2;
    else if (vf_err) return 3'd4;
    else             return lock_code;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_out, w_out_nxt;
  logic [7:0]  r_div, w_div_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic        r_drp_err, w_drp_err_nxt;
  logic        r_vf_err, w_vf_err_nxt;
  logic [2:0]  r_status, w_status_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_mmcm_rst, w_mmcm_rst_nxt;
  logic        r_clk_en, w_clk_en_nxt;
  logic        r_drp_en, w_drp_en_nxt;
  logic        r_drp_we, w_drp_we_nxt;
  logic [6:0]  r_drp_addr, w_drp_addr_nxt;
  logic [15:0] r_drp_di, w_drp_di_nxt;
  logic        r_lock_s1, r_lock_s2;
  logic [6:0]  w_addr1;
  logic        w_bad_req;

  assign w_addr1   = reg1_addr(r_out);
  assign w_bad_req = (r_out == 3'd7) || (r_div == 8'd0) || (r_div > 8'd128);

  // Two-flop synchroniser for the asynchronous LOCKED input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= mmcm_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // Next-state and registered-output logic; DRP accesses launch on entry to an access state.
  always_comb begin
    w_state_nxt    = r_state;
    w_out_nxt      = r_out;
    w_div_nxt      = r_div;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_drp_err_nxt  = r_drp_err;
    w_vf_err_nxt   = r_vf_err;
    w_status_nxt   = r_status;
    w_mmcm_rst_nxt = r_mmcm_rst;
    w_clk_en_nxt   = r_clk_en;
    w_drp_en_nxt   = 1'b0;
    w_drp_we_nxt   = 1'b0;
    w_drp_addr_nxt = r_drp_addr;
    w_drp_di_nxt   = r_drp_di;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt    = r_cnt;
        w_clk_en_nxt = r_lock_s2;
        if (bus.req_valid && r_ready) begin
          w_out_nxt     = bus.req_output;
          w_div_nxt     = bus.req_divide;
          w_drp_err_nxt = 1'b0;
          w_vf_err_nxt  = 1'b0;
          w_state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_bad_req) begin
          w_status_nxt = 3'd1;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt  = S_RST_HOLD;
        end
      end
      S_RST_HOLD: begin
        if (r_cnt == CNT_W'(RST_HOLD - 1)) w_state_nxt = S_RD1;
      end
      S_RD1, S_WR1, S_RD2, S_WR2
`ifdef MMCM_DRP_READBACK_EN
      , S_VF1, S_VF2
`endif
      : begin
        if (bus.drp_rdy) begin
          case (r_state)
            S_RD1: w_state_nxt = S_WR1;
            S_RD2: w_state_nxt = S_WR2;
`ifdef MMCM_DRP_READBACK_EN
            S_WR1: w_state_nxt = S_VF1;
            S_WR2: w_state_nxt = S_VF2;
            S_VF1: begin
              w_vf_err_nxt = (bus.drp_do != r_drp_di);
              w_state_nxt  = (bus.drp_do != r_drp_di) ? S_RELEASE : S_RD2;
            end
            S_VF2: begin
              w_vf_err_nxt = (bus.drp_do != r_drp_di);
              w_state_nxt  = S_RELEASE;
            end
`else
            S_WR1: w_state_nxt = S_RD2;
            S_WR2: w_state_nxt = S_RELEASE;
`endif
            default: w_state_nxt = S_RELEASE;
          endcase
        end else if (r_cnt == CNT_W'(DRP_TIMEOUT - 1)) begin
          w_drp_err_nxt = 1'b1;
          w_state_nxt   = S_RELEASE;
        end
      end
      S_RELEASE: w_state_nxt = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        if (r_cnt >= CNT_W'(LOCK_BLANK) && r_lock_s2) begin
          w_clk_en_nxt = 1'b1;
          w_status_nxt = final_status(r_drp_err, r_vf_err, 3'd0);
          w_state_nxt  = S_DONE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_status_nxt = final_status(r_drp_err, r_vf_err, 3'd3);
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      case (w_state_nxt)
        S_RST_HOLD: begin
          w_mmcm_rst_nxt = 1'b1;
          w_clk_en_nxt   = 1'b0;
        end
        S_RD1, S_VF1: begin
          w_drp_en_nxt   = 1'b1;
          w_drp_addr_nxt = w_addr1;
        end
        S_RD2, S_VF2: begin
          w_drp_en_nxt   = 1'b1;
          w_drp_addr_nxt = w_addr1 + 7'd1;
        end
        S_WR1: begin
          w_drp_en_nxt   = 1'b1;
          w_drp_we_nxt   = 1'b1;
          w_drp_addr_nxt = w_addr1;
          w_drp_di_nxt   = {bus.drp_do[15:12], enc_hilo(r_div)};
        end
        S_WR2: begin
          w_drp_en_nxt   = 1'b1;
          w_drp_we_nxt   = 1'b1;
          w_drp_addr_nxt = w_addr1 + 7'd1;
          w_drp_di_nxt   = enc_reg2(bus.drp_do, r_div);
        end
        S_RELEASE: w_mmcm_rst_nxt = 1'b0;
        default: ;
      endcase
    end

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_out      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_drp_err  <= 1'b0;
      r_vf_err   <= 1'b0;
      r_status   <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mmcm_rst <= 1'b0;
      r_clk_en   <= 1'b0;
      r_drp_en   <= 1'b0;
      r_drp_we   <= 1'b0;
      r_drp_addr <= '0;
      r_drp_di   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_div      <= w_div_nxt;
      r_cnt      <= w_cnt_nxt;
      r_drp_err  <= w_drp_err_nxt;
      r_vf_err   <= w_vf_err_nxt;
      r_status   <= w_status_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_mmcm_rst <= w_mmcm_rst_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_drp_en   <= w_drp_en_nxt;
      r_drp_we   <= w_drp_we_nxt;
      r_drp_addr <= w_drp_addr_nxt;
      r_drp_di   <= w_drp_di_nxt;
    end
  end

  assign bus.req_ready   = r_ready;
  assign bus.done_valid  = r_done;
  assign bus.done_status = r_status;
  assign bus.busy        = r_busy;
  assign bus.drp_en      = r_drp_en;
  assign bus.drp_we      = r_drp_we;
  assign bus.drp_addr    = r_drp_addr;
  assign bus.drp_di      = r_drp_di;
  assign mmcm_rst        = r_mmcm_rst;
  assign clk_en          = r_clk_en;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig: behavioural DRP register file, MMCM lock model
// and hand-computed expected register contents and statuses.
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig;
  localparam int RST_HOLD     = 4;
  localparam int DRP_TIMEOUT  = 16;
  localparam int LOCK_TIMEOUT = 100;
`ifdef MMCM_DRP_READBACK_EN
  localparam int         NACC    = 6;
  localparam logic [2:0] CORR_ST = 3'd4;
`else
  localparam int         NACC    = 4;
  localparam logic [2:0] CORR_ST = 3'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mmcm_rst;
  logic mmcm_locked = 1'b0;
  logic clk_en;

  mmcm_drp_reconfig_if bus();

  mmcm_drp_reconfig #(
    .RST_HOLD(RST_HOLD), .DRP_TIMEOUT(DRP_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked), .clk_en(clk_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:127];
  bit          written [0:127];
  logic [15:0] rd_data;
  int  pend_cnt = 0;
  bit  withhold = 0, corrupt = 0;
  logic [6:0] corrupt_addr = 7'h0B;
  bit  lock_en = 1;
  int  lock_delay = 20, lock_cnt = 0;
  int  n_en, n_we, done_cnt = 0, accept_cnt, overlap_cnt = 0, rst_pre, rel_cnt;
  bit  en_seen, clk_en_low_seen, mmcm_rst_seen, prev_busy = 0;
  logic [2:0] st;
  int  lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lock model, DRP register file and activity monitor, all on the falling edge.
  always @(negedge clk) begin
    if (mmcm_rst || !lock_en) begin
      mmcm_locked = 1'b0;
      lock_cnt = 0;
    end else if (lock_cnt < lock_delay) lock_cnt++;
    else mmcm_locked = 1'b1;

    bus.drp_rdy = 1'b0;
    if (!rst_n) pend_cnt = 0;
    else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.drp_rdy = 1'b1;
          bus.drp_do  = rd_data;
        end
      end
      if (bus.drp_en) begin
        n_en++;
        if (bus.drp_we) begin
          n_we++;
          mem[bus.drp_addr] = bus.drp_di;
          written[bus.drp_addr] = 1'b1;
          rd_data = 16'h0;
          if (!withhold) pend_cnt = 2;
        end else begin
          rd_data = (corrupt && written[bus.drp_addr] && bus.drp_addr == corrupt_addr)
                    ? (mem[bus.drp_addr] ^ 16'h8000) : mem[bus.drp_addr];
          pend_cnt = 2;
        end
      end
    end

    if (bus.busy && !prev_busy) accept_cnt++;
    prev_busy = bus.busy;
    if (bus.done_valid) done_cnt++;
    if (bus.busy && bus.req_ready) overlap_cnt++;
    if (bus.busy && !clk_en) clk_en_low_seen = 1;
    if (mmcm_rst) mmcm_rst_seen = 1;
    if (bus.busy && en_seen && !mmcm_rst) rel_cnt++;
    if (!en_seen) begin
      if (bus.drp_en) en_seen = 1;
      else if (mmcm_rst) rst_pre++;
    end
  end

  task automatic clr_stats();
    n_en = 0; n_we = 0; en_seen = 0; rst_pre = 0; rel_cnt = 0; accept_cnt = 0;
    clk_en_low_seen = 0; mmcm_rst_seen = 0;
    for (int i = 0; i < 128; i++) written[i] = 1'b0;
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_output = o; bus.req_divide = d;
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_output = 3'd7; bus.req_divide = 8'd0;
  endtask

  task automatic wait_done(input string tag, input int budget, output logic [2:0] s, output int l);
    l = 0;
    while (!bus.done_valid && l < budget) begin @(negedge clk); l++; end
    check_eq({tag, "_done_seen"}, bus.done_valid, 1'b1);
    s = bus.done_status;
  endtask

  task automatic run_req(input string tag, input logic [2:0] o, input logic [7:0] d,
                         input int budget, output logic [2:0] s);
    clr_stats();
    send(o, d);
    wait_done(tag, budget, s, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_output = '0; bus.req_divide = '0;
    bus.drp_rdy = 1'b0; bus.drp_do = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    clr_stats();

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 1'b0);
    check_eq("rst_busy_done", {bus.busy, bus.done_valid, bus.done_status}, 5'h0);
    check_eq("rst_mmcm_clk",  {mmcm_rst, clk_en}, 2'b00);
    check_eq("rst_drp", {bus.drp_en, bus.drp_we, bus.drp_addr, bus.drp_di}, 25'h0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("idle_ready", bus.req_ready, 1'b1);
    check_eq("idle_clk_en_follows_lock", clk_en, 1'b1);

    // D=10 on CLK1
    mem[7'h0A] = 16'hE000; mem[7'h0B] = 16'h00C3;
    run_req("A", 3'd1, 8'd10, 400, st);
    check_eq("A_status", st, 3'd0);
    check_eq("A_reg1", mem[7'h0A], 16'hE145);
    check_eq("A_reg2", mem[7'h0B], 16'h0003);
    check_eq("A_writes", n_we, 2);
    check_eq("A_accesses", n_en, NACC);
    check_eq("A_rst_hold", rst_pre, RST_HOLD);
    check_eq("A_clk_en_was_low", clk_en_low_seen, 1'b1);
    check_eq("A_clk_en_high", clk_en, 1'b1);
    check_eq("A_mmcm_rst", mmcm_rst, 1'b0);
    check_eq("A_accepts", accept_cnt, 1);

    // Encoding corners over several outputs
    mem[7'h06] = 16'h5FFF; mem[7'h07] = 16'hFF3F;
    run_req("B", 3'd5, 8'd7, 400, st);
    check_eq("B_status", st, 3'd0);
    check_eq("B_reg1_d7", mem[7'h06], 16'h50C4);
    check_eq("B_reg2_d7", mem[7'h07], 16'hFFBF);

    mem[7'h0E] = 16'h0000; mem[7'h0F] = 16'h0000;
    run_req("C", 3'd3, 8'd1, 400, st);
    check_eq("C_reg1_d1", mem[7'h0E], 16'h0041);
    check_eq("C_reg2_d1", mem[7'h0F], 16'h00C0);

    mem[7'h08] = 16'h1FFF; mem[7'h09] = 16'h00C0;
    run_req("D", 3'd0, 8'd128, 400, st);
    check_eq("D_reg1_d128", mem[7'h08], 16'h1000);
    check_eq("D_reg2_d128", mem[7'h09], 16'h0000);

    mem[7'h10] = 16'h0000; mem[7'h11] = 16'hFFFF;
    run_req("E", 3'd4, 8'd64, 400, st);
    check_eq("E_reg1_d64", mem[7'h10], 16'h0820);
    check_eq("E_reg2_d64", mem[7'h11], 16'hFF3F);

    mem[7'h12] = 16'hF000; mem[7'h13] = 16'h00C0;
    run_req("F", 3'd6, 8'd2, 400, st);
    check_eq("F_reg1_clk6", mem[7'h12], 16'hF041);
    check_eq("F_reg2_clk6", mem[7'h13], 16'h0000);

    // Bad requests
    run_req("G0", 3'd7, 8'd10, 10, st);
    check_eq("G0_status", st, 3'd1);
    check_eq("G0_latency_ok", lat <= 3, 1'b1);
    check_eq("G0_no_drp", n_en, 0);
    check_eq("G0_no_mmcm_rst", mmcm_rst_seen, 1'b0);
    run_req("G1", 3'd2, 8'd0, 10, st);
    check_eq("G1_status", st, 3'd1);
    check_eq("G1_no_drp", n_en, 0);
    run_req("G2", 3'd2, 8'd129, 10, st);
    check_eq("G2_status", st, 3'd1);
    check_eq("G2_no_drp_rst", {n_en[7:0], mmcm_rst_seen}, 9'h0);
    check_eq("G2_clk_en_untouched", clk_en, 1'b1);

    // DRP timeout on WR1
    withhold = 1;
    run_req("T", 3'd2, 8'd10, 400, st);
    check_eq("T_status", st, 3'd2);
    check_eq("T_accesses", n_en, 2);
    check_eq("T_mmcm_rst_released", mmcm_rst, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("T_no_more_en", n_en, 2);
    withhold = 0;

    // Lock never arrives
    lock_en = 0;
    run_req("L", 3'd0, 8'd10, 600, st);
    check_eq("L_status", st, 3'd3);
    check_eq("L_window", (rel_cnt >= LOCK_TIMEOUT) && (rel_cnt <= LOCK_TIMEOUT + 4), 1'b1);
    check_eq("L_clk_en_low", clk_en, 1'b0);
    lock_en = 1;
    repeat (30) @(negedge clk);
    check_eq("L_clk_en_idle", clk_en, 1'b1);

    // Reset pulse during WR2
    clr_stats();
    mem[7'h0A] = 16'hE000; mem[7'h0B] = 16'h00C3;
    send(3'd1, 8'd10);
    lat = 0;
    while (!(bus.drp_en && bus.drp_we && bus.drp_addr == 7'h0B) && lat < 200) begin
      @(negedge clk); lat++;
    end
    check_eq("R_reached_wr2", bus.drp_en && bus.drp_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("R_ready_busy_done", {bus.req_ready, bus.busy, bus.done_valid, bus.done_status}, 6'h0);
    check_eq("R_mmcm_clk", {mmcm_rst, clk_en}, 2'b00);
    check_eq("R_drp", {bus.drp_en, bus.drp_we, bus.drp_addr, bus.drp_di}, 25'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check_eq("R_no_done", done_cnt, d0);
    end
    mem[7'h0E] = 16'hABCD; mem[7'h0F] = 16'h0000;
    run_req("R2", 3'd3, 8'd10, 400, st);
    check_eq("R2_status", st, 3'd0);
    check_eq("R2_reg1", mem[7'h0E], 16'hA145);

    // req_valid held across the whole transaction
    clr_stats();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_output = 3'd1; bus.req_divide = 8'd10;
    lat = 0;
    while (!bus.done_valid && lat < 400) begin @(negedge clk); lat++; end
    check_eq("H_done_seen", bus.done_valid, 1'b1);
    check_eq("H_status", bus.done_status, 3'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("H_accepts", accept_cnt, 1);
    check_eq("H_ready_busy_overlap", overlap_cnt, 0);

    // Readback corruption of ClkReg2
    corrupt = 1; corrupt_addr = 7'h0B;
    mem[7'h0A] = 16'hE000; mem[7'h0B] = 16'h00C3;
    run_req("V", 3'd1, 8'd10, 400, st);
    check_eq("V_status", st, CORR_ST);
    check_eq("V_accesses", n_en, NACC);
    corrupt = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
